// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared encodings and constants for the register-specified shift sequencer
//
// Purpose: shift-type encodings, sequencer state type and effective-amount bound
// used by shift_sequencer and shift_step.
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Any LSL/LSR/ASR amount above 33 behaves exactly like 33.
  localparam int MAX_EFF_AMT = 33;
  localparam int REM_W       = 6;
  localparam int K_W         = 4;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter (k bits, ARM shift types)
//
// Purpose: shift a 32-bit value by k (0..8) bits of the given type and report
// the last bit shifted out (ARM carry semantics). last_out is only meaningful
// for k >= 1.
// Ports:
//   i_value  in  32  value to shift
//   i_type   in  2   SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   i_k      in  4   shift distance for this step
//   o_value  out 32  shifted value
//   o_last   out 1   last bit shifted out
module shift_step
  import shifter_pkg::*;
(
  input  logic [31:0]    i_value,
  input  logic [1:0]     i_type,
  input  logic [K_W-1:0] i_k,
  output logic [31:0]    o_value,
  output logic           o_last
);

  logic        [32:0] w_lsl;
  logic        [32:0] w_lsr;
  logic signed [32:0] w_asr;
  logic        [31:0] w_ror;
  logic        [5:0]  w_lsh;

  // One guard bit on the exit side of each shift captures the last bit out.
  always_comb begin
    w_lsl = {1'b0, i_value} << i_k;
    w_lsr = {i_value, 1'b0} >> i_k;
    w_asr = $signed({i_value, 1'b0}) >>> i_k;
    w_lsh = 6'd32 - {2'b00, i_k};
    w_ror = (i_value >> i_k) | (i_value << w_lsh);
  end

  always_comb begin
    o_value = i_value;
    o_last  = 1'b0;
    case (i_type)
      SH_LSL: begin
        o_value = w_lsl[31:0];
        o_last  = w_lsl[32];
      end
      SH_LSR: begin
        o_value = w_lsr[32:1];
        o_last  = w_lsr[0];
      end
      SH_ASR: begin
        o_value = w_asr[32:1];
        o_last  = w_asr[0];
      end
      default: begin
        o_value = w_ror;
        o_last  = w_ror[31];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle register-specified shift controller with pipeline stall
//
// Purpose: latches Rm, shift type and Rs[7:0], iterates STEP bits per cycle and
// returns the ARM shifter result and carry-out, stalling IF/ID/EXE meanwhile.
// Optional feature macro: SHIFT_SEQ_SATURATE_EN (LSL/LSR/ASR with amount >= 32
// resolved at acceptance, straight to DONE).
// Ports:
//   clk        in  1      system clock
//   rst        in  1      synchronous active-high reset
//   start      in  1      request a shift; accepted in IDLE or DONE
//   flush      in  1      abort current operation, no done issued
//   val_rm     in  32     operand to shift
//   shift_type in  2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   shift_amt  in  AMT_W  Rs[7:0]
//   carry_in   in  1      current CPSR C flag
//   result     out 32     shifted value, held after done
//   carry_out  out 1      shifter carry-out, held after done
//   done       out 1      one-cycle pulse, result valid
//   busy       out 1      shift in progress
//   stall      out 1      start accepted this cycle or busy
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int STEP  = 4,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [31:0]      val_rm,
  input  logic [1:0]       shift_type,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic             carry_in,
  output logic [31:0]      result,
  output logic             carry_out,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [31:0]      r_wv;
  logic [1:0]       r_type;
  logic [REM_W-1:0] r_rem;
  logic [31:0]      r_result;
  logic             r_carry;

  logic             w_accept;
  logic [REM_W-1:0] w_n;
  logic [K_W-1:0]   w_k;
  logic [31:0]      w_step_val;
  logic             w_step_last;
  logic             w_sat;
  logic [31:0]      w_sat_val;
  logic             w_sat_c;
  logic [31:0]      w_load_val;
  logic             w_load_c;

  // Effective iteration count; ROR by a non-zero multiple of 32 rotates a full word.
  always_comb begin
    w_n = '0;
    if (shift_type == SH_ROR) begin
      if (shift_amt == '0)
        w_n = '0;
      else if (shift_amt[4:0] == 5'd0)
        w_n = REM_W'(32);
      else
        w_n = {1'b0, shift_amt[4:0]};
    end else if (shift_amt > AMT_W'(MAX_EFF_AMT)) begin
      w_n = REM_W'(MAX_EFF_AMT);
    end else begin
      w_n = shift_amt[REM_W-1:0];
    end
  end

`ifdef SHIFT_SEQ_SATURATE_EN
  always_comb begin
    w_sat     = (shift_type != SH_ROR) && (shift_amt >= AMT_W'(32));
    w_sat_val = '0;
    w_sat_c   = 1'b0;
    case (shift_type)
      SH_LSL:  w_sat_c = (shift_amt == AMT_W'(32)) ? val_rm[0] : 1'b0;
      SH_LSR:  w_sat_c = (shift_amt == AMT_W'(32)) ? val_rm[31] : 1'b0;
      SH_ASR: begin
        w_sat_val = {32{val_rm[31]}};
        w_sat_c   = val_rm[31];
      end
      default: ;
    endcase
  end
`else
  assign w_sat     = 1'b0;
  assign w_sat_val = '0;
  assign w_sat_c   = 1'b0;
`endif

  assign w_load_val = w_sat ? w_sat_val : val_rm;
  assign w_load_c   = w_sat ? w_sat_c : carry_in;

  assign w_k = (r_rem < STEP_R) ? r_rem[K_W-1:0] : STEP_R[K_W-1:0];

  shift_step u_step (
    .i_value (r_wv),
    .i_type  (r_type),
    .i_k     (w_k),
    .o_value (w_step_val),
    .o_last  (w_step_last)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_next = IDLE;
        if (start) begin
          w_accept = 1'b1;
          w_next   = (w_n == '0 || w_sat) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // rem - k reaches zero exactly when rem fits in one step.
        if (r_rem <= STEP_R)
          w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
    if (flush || rst) begin
      w_next   = IDLE;
      w_accept = 1'b0;
    end
  end

  // result/carry_out are separate from the working register so a flushed
  // operation leaves the last delivered result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wv     <= '0;
      r_type   <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_wv   <= w_load_val;
      r_type <= shift_type;
      r_rem  <= w_n;
      if (w_next == DONE) begin
        r_result <= w_load_val;
        r_carry  <= w_load_c;
      end
    end else if (r_state == SHIFT && !flush) begin
      r_wv  <= w_step_val;
      r_rem <= r_rem - {{(REM_W-K_W){1'b0}}, w_k};
      if (w_next == DONE) begin
        r_result <= w_step_val;
        r_carry  <= w_step_last;
      end
    end
  end

  assign done      = (r_state == DONE);
  assign busy      = (r_state == SHIFT);
  assign stall     = w_accept | busy;
  assign result    = r_result;
  assign carry_out = r_carry;

endmodule
